pilha_rpn_parametrizada: RTL

Parametrised successor to the fixed 8-bit, 4-entry RPN stack. Holds DEPTH operands of WIDTH bits and executes RPN operations on the top entries. Provides a sequential shift-add multiplier, DUP/SWAP, sticky error flags and a busy handshake. Sits between the input/clock-control logic and the HEX/LED display path of the calculator top level.

---
 rtl/pilha_rpn_pkg.sv | 26 ++
 rtl/multiplicador_seq.sv | 61 ++++++
 rtl/pilha_rpn_parametrizada.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pilha_rpn_pkg.sv
// Shared definitions for the parametrised RPN stack.
// Contents: opcode encodings, erro bit positions and the state encoding of
// the multiply sequencer used by pilha_rpn_parametrizada.
package pilha_rpn_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_DUP  = 3'b110;
    localparam logic [2:0] OP_SWAP = 3'b111;

    // Bit positions inside the sticky erro vector.
    localparam int ERRO_OVERFLOW  = 0;
    localparam int ERRO_UNDERFLOW = 1;
    localparam int ERRO_COMANDO   = 2;

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        MULT    = 2'b01,
        ESCRITA = 2'b10
    } estado_mul_t;

endpackage

// File: rtl/multiplicador_seq.sv
// Sequential shift-add multiplier, one multiplier bit per clock.
// Ports:
//   clk, rst      clock and asynchronous active-low reset
//   start         loads a and b and begins WIDTH iterations
//   a, b          operands (a is shifted left, b is scanned LSB first)
//   busy          high while iterations remain
//   done          high during the cycle of the final iteration, so the
//                 caller can change state on the same edge the product settles
//   produto       full 2*WIDTH-bit product, held once busy falls
module multiplicador_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   produto
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acumulador;
    logic [2*WIDTH-1:0] multiplicando;
    logic [WIDTH-1:0]   multiplicador;
    logic [CW-1:0]      restantes;

    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acumulador    <= '0;
            multiplicando <= '0;
            multiplicador <= '0;
            restantes     <= '0;
            busy          <= 1'b0;
        end else if (start) begin
            acumulador    <= '0;
            multiplicando <= {{WIDTH{1'b0}}, a};
            multiplicador <= b;
            restantes     <= CW'(WIDTH);
            busy          <= 1'b1;
        end else if (busy) begin
            if (multiplicador[0]) begin
                acumulador <= acumulador + multiplicando;
            end
            multiplicando <= multiplicando << 1;
            multiplicador <= multiplicador >> 1;
            restantes     <= restantes - CW'(1);
            if (restantes == CW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

    assign done    = busy && (restantes == CW'(1));
    assign produto = acumulador;

endmodule

// File: rtl/pilha_rpn_parametrizada.sv
// Parametrised RPN operand stack with ALU, sequential multiplier, DUP/SWAP,
// sticky error flags and a busy handshake.
// The stack is a shift register: entry 0 is the top, entry 1 the second, and
// unused entries are kept at zero so the display outputs read 0 naturally.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   entrada                  operand pushed on entrada_numero
//   operacao                 opcode sampled on entrada_operacao
//   entrada_numero           push strobe
//   entrada_operacao         operation strobe
//   limpar_erro              clears sticky erro (a same-cycle new error wins)
//   resultado, display_b     top of stack
//   display_a                second entry
//   contagem                 number of entries held
//   pilha_vazia/pilha_cheia  empty / full status
//   ocupado                  multiply in progress, all strobes rejected
//   flag_carry, flag_zero    status of the last result written to the top
//   erro                     sticky [0] overflow, [1] underflow, [2] rejected
// Build option: define PILHA_SATURACAO_EN to clamp ADD/MUL to all-ones and
// SUB to zero instead of wrapping.
module pilha_rpn_parametrizada
    import pilha_rpn_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           entrada,
    input  logic [2:0]                 operacao,
    input  logic                       entrada_numero,
    input  logic                       entrada_operacao,
    input  logic                       limpar_erro,
    output logic [WIDTH-1:0]           resultado,
    output logic [WIDTH-1:0]           display_a,
    output logic [WIDTH-1:0]           display_b,
    output logic [$clog2(DEPTH+1)-1:0] contagem,
    output logic                       pilha_vazia,
    output logic                       pilha_cheia,
    output logic                       ocupado,
    output logic                       flag_carry,
    output logic                       flag_zero,
    output logic [2:0]                 erro
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   pilha [DEPTH];
    logic [CW-1:0]      contagem_q, contagem_prox;
    estado_mul_t        estado;

    logic               faz_push, faz_bin, faz_dup, faz_swap, inicia_mul, escreve_mul;
    logic [2:0]         novo_erro;
    logic               cheia;

    logic [WIDTH:0]     soma, diferenca;
    logic [WIDTH-1:0]   res_bin, res_mul;
    logic               carry_bin, mul_estouro;

    logic               mul_busy, mul_done;
    logic [2*WIDTH-1:0] produto;

    multiplicador_seq #(.WIDTH(WIDTH)) u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (inicia_mul),
        .a       (pilha[1]),
        .b       (pilha[0]),
        .busy    (mul_busy),
        .done    (mul_done),
        .produto (produto)
    );

    assign cheia       = (contagem_q == CW'(DEPTH));
    assign escreve_mul = (estado == ESCRITA);

    // Command decode: at most one action per cycle, otherwise an error bit.
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        faz_push   = 1'b0;
        faz_bin    = 1'b0;
        faz_dup    = 1'b0;
        faz_swap   = 1'b0;
        inicia_mul = 1'b0;
        novo_erro  = '0;
        if (estado != OCIOSO) begin
            if (entrada_numero || entrada_operacao) novo_erro[ERRO_COMANDO] = 1'b1;
        end else if (entrada_numero && entrada_operacao) begin
            novo_erro[ERRO_COMANDO] = 1'b1;
        end else if (entrada_numero) begin
            if (cheia) novo_erro[ERRO_OVERFLOW] = 1'b1;
            else       faz_push = 1'b1;
        end else if (entrada_operacao) begin
            case (operacao)
                OP_DUP: begin
                    if (contagem_q == '0) novo_erro[ERRO_UNDERFLOW] = 1'b1;
                    else if (cheia)       novo_erro[ERRO_OVERFLOW]  = 1'b1;
                    else                  faz_dup = 1'b1;
                end
                OP_SWAP: begin
                    if (contagem_q < CW'(2)) novo_erro[ERRO_UNDERFLOW] = 1'b1;
                    else                     faz_swap = 1'b1;
                end
                OP_MUL: begin
                    if (contagem_q < CW'(2)) novo_erro[ERRO_UNDERFLOW] = 1'b1;
                    else                     inicia_mul = 1'b1;
                end
                default: begin
                    if (contagem_q < CW'(2)) novo_erro[ERRO_UNDERFLOW] = 1'b1;
                    else                     faz_bin = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        contagem_prox = contagem_q;
        if (faz_push || faz_dup)          contagem_prox = contagem_q + CW'(1);
        else if (faz_bin || escreve_mul)  contagem_prox = contagem_q - CW'(1);
    end

    // Single-cycle ALU on A = second entry, B = top entry.
    assign soma      = {1'b0, pilha[1]} + {1'b0, pilha[0]};
    assign diferenca = {1'b0, pilha[1]} - {1'b0, pilha[0]};

    always_comb begin
        res_bin   = '0;
        carry_bin = 1'b0;
        case (operacao)
            OP_ADD: begin
                carry_bin = soma[WIDTH];
`ifdef PILHA_SATURACAO_EN
                res_bin   = soma[WIDTH] ? '1 : soma[WIDTH-1:0];
`else
                res_bin   = soma[WIDTH-1:0];
`endif
            end
            OP_SUB: begin
                carry_bin = diferenca[WIDTH];
`ifdef PILHA_SATURACAO_EN
                res_bin   = diferenca[WIDTH] ? '0 : diferenca[WIDTH-1:0];
`else
                res_bin   = diferenca[WIDTH-1:0];
`endif
            end
            OP_AND:  res_bin = pilha[1] & pilha[0];
            OP_OR:   res_bin = pilha[1] | pilha[0];
            OP_XOR:  res_bin = pilha[1] ^ pilha[0];
            default: res_bin = '0;
        endcase
    end

    assign mul_estouro = |produto[2*WIDTH-1:WIDTH];
`ifdef PILHA_SATURACAO_EN
    assign res_mul = mul_estouro ? '1 : produto[WIDTH-1:0];
`else
    assign res_mul = produto[WIDTH-1:0];
`endif

    // NOTE: the stack array is small and must read zero after reset (it drives
    // the displays), so it is reset along with the control registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) pilha[i] <= '0;
            contagem_q  <= '0;
            pilha_vazia <= 1'b1;
            pilha_cheia <= 1'b0;
            flag_carry  <= 1'b0;
            flag_zero   <= 1'b0;
            erro        <= '0;
            ocupado     <= 1'b0;
            estado      <= OCIOSO;
        end else begin
            erro        <= (limpar_erro ? 3'b000 : erro) | novo_erro;
            contagem_q  <= contagem_prox;
            pilha_vazia <= (contagem_prox == '0);
            pilha_cheia <= (contagem_prox == CW'(DEPTH));

            case (estado)
                OCIOSO: begin
                    if (inicia_mul) begin
                        estado  <= MULT;
                        ocupado <= 1'b1;
                    end
                end
                MULT: begin
                    if (mul_done) estado <= ESCRITA;
                end
                ESCRITA: begin
                    estado  <= OCIOSO;
                    ocupado <= 1'b0;
                end
                default: estado <= OCIOSO;
            endcase

            if (faz_push || faz_dup) begin
                pilha[0] <= faz_push ? entrada : pilha[0];
                for (int i = 1; i < DEPTH; i++) pilha[i] <= pilha[i-1];
            end else if (faz_bin || escreve_mul) begin
                pilha[0] <= faz_bin ? res_bin : res_mul;
                for (int i = 1; i < DEPTH - 1; i++) pilha[i] <= pilha[i+1];
                pilha[DEPTH-1] <= '0;
            end else if (faz_swap) begin
                pilha[0] <= pilha[1];
                pilha[1] <= pilha[0];
            end

            if (faz_bin) begin
                flag_carry <= carry_bin;
                flag_zero  <= (res_bin == '0);
            end else if (escreve_mul) begin
                flag_carry <= mul_estouro;
                flag_zero  <= (res_mul == '0);
            end else if (faz_dup) begin
                flag_carry <= 1'b0;
                flag_zero  <= (pilha[0] == '0);
            end else if (faz_swap) begin
                flag_carry <= 1'b0;
                flag_zero  <= (pilha[1] == '0);
            end
        end
    end

    assign resultado = pilha[0];
    assign display_b = pilha[0];
    assign display_a = pilha[1];
    assign contagem  = contagem_q;

endmodule
